// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline barriers
// Load-use bubbles, taken-branch squash, data-memory wait freeze, saturating stall counter.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic [4:0]       exRd,
    input  logic             exMemToReg,
    input  logic             exBranchTaken,
    input  logic             memMemRead,
    input  logic             memMemWrite,
    input  logic             dmemReady,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExWrite,
    output logic             idExFlush,
    output logic             exMemWrite,
    output logic             memWbFlush,
    output logic [CNT_W-1:0] stallCount,
    output logic             memTimeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t             state, nextState;
    logic [WAIT_W-1:0]  waitCnt, nextWaitCnt;
    logic               setTimeout;
    logic               loadUse;
    logic               memBusy;

    assign loadUse = exMemToReg && (exRd != 5'd0) && ((exRd == idRs1) || (exRd == idRs2));
    assign memBusy = (memMemRead || memMemWrite) && !dmemReady;

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExWrite   = 1'b1;
        idExFlush   = 1'b0;
        exMemWrite  = 1'b1;
        memWbFlush  = 1'b0;
        nextState   = state;
        nextWaitCnt = waitCnt;
        setTimeout  = 1'b0;

        if (reset || state == ERROR) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b1;
            idExWrite  = 1'b0;
            idExFlush  = 1'b1;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
        end else if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbFlush = 1'b1;
            if (state == RUN) begin
                nextState   = MEM_WAIT;
                nextWaitCnt = WAIT_W'(1);
            end else begin
                nextWaitCnt = waitCnt + 1'b1;
                if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    nextState  = ERROR;
                    setTimeout = 1'b1;
                end
            end
        end else begin
            // A finished or withdrawn access releases in the same cycle, evaluated as RUN.
            nextState   = RUN;
            nextWaitCnt = '0;
            if (exBranchTaken) begin
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end else if (loadUse) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                idExFlush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            waitCnt    <= '0;
            stallCount <= '0;
            memTimeout <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (setTimeout)
                memTimeout <= 1'b1;
            if (!pcWrite && stallCount != {CNT_W{1'b1}})
                stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed vector bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;
    // {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush}
    localparam logic [6:0] DEF  = 7'b1101010;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] FRZ  = 7'b0000001;
    localparam logic [6:0] HALT = 7'b0010101;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       idRs1, idRs2, exRd;
    logic             exMemToReg, exBranchTaken, memMemRead, memMemWrite, dmemReady;
    logic             pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush;
    logic [CNT_W-1:0] stallCount;
    logic             memTimeout;

    int compared = 0;
    int mismatched = 0;
    int expStall = 0;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .idRs1(idRs1), .idRs2(idRs2), .exRd(exRd),
        .exMemToReg(exMemToReg), .exBranchTaken(exBranchTaken),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite), .dmemReady(dmemReady),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
        .memWbFlush(memWbFlush), .stallCount(stallCount), .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       ld, br, mr, mw, rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic ld, input logic br, input logic mr, input logic mw,
                         input logic rdy);
        idRs1 = r1; idRs2 = r2; exRd = rd;
        exMemToReg = ld; exBranchTaken = br;
        memMemRead = mr; memMemWrite = mw; dmemReady = rdy;
    endtask

    task automatic checkOut(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: outputs got %b expected %b", name, got, exp);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[1] = '{"lu_rs2",      5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[2] = '{"lu_rs1",      5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[3] = '{"x0_nostall",  5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[4] = '{"nomatch",     5'd4, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[5] = '{"notload",     5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[6] = '{"br_and_lu",   5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BR};
        vecs[7] = '{"br_only",     5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BR};
        vecs[8] = '{"rd_ready",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DEF};
        vecs[9] = '{"wr_ready_lu", 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, LU};

        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOut("reset_outputs", HALT);
        checkVal("reset_stallCount", int'(stallCount), 0);
        checkVal("reset_memTimeout", int'(memTimeout), 0);
        reset = 1'b0;

        // Single-cycle RUN-state vectors; stall count follows the expected pcWrite.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ld, vecs[i].br,
                  vecs[i].mr, vecs[i].mw, vecs[i].rdy);
            #2;
            checkOut(vecs[i].name, vecs[i].exp);
            if (!vecs[i].exp[6]) expStall++;
            @(posedge clk);
            #1;
            checkVal({vecs[i].name, "_stallCount"}, int'(stallCount), expStall);
        end

        // Memory wait: three busy cycles, release on the fourth.
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #2;
            checkOut("memwait_freeze", FRZ);
        end
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        checkOut("memwait_release", DEF);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOut("after_release", DEF);
        checkVal("memwait_stallCount", int'(stallCount), 3);

        // Request withdrawn inside MEM_WAIT: behaves as RUN with a branch.
        pulseReset();
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        checkOut("drop_enter", FRZ);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checkOut("drop_branch", BR);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOut("drop_idle", DEF);
        checkVal("drop_stallCount", int'(stallCount), 1);

        // Timeout: four frozen cycles, then sticky ERROR.
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #2;
            checkOut("timeout_freeze", FRZ);
            checkVal("timeout_flag_pre", int'(memTimeout), 0);
        end
        @(negedge clk);
        #2;
        checkOut("error_state", HALT);
        checkVal("error_flag", int'(memTimeout), 1);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOut("error_ready_held", HALT);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        #2;
        checkOut("error_sticky", HALT);
        checkVal("error_flag_sticky", int'(memTimeout), 1);
        checkVal("stallCount_saturated", int'(stallCount), 15);

        // Asynchronous reset between edges while in MEM_WAIT.
        pulseReset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #2;
            checkOut("async_pre_freeze", FRZ);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOut("async_reset_outputs", HALT);
        checkVal("async_reset_stallCount", int'(stallCount), 0);
        checkVal("async_reset_memTimeout", int'(memTimeout), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOut("post_reset_idle", DEF);
        @(posedge clk);
        #1;
        checkVal("post_reset_stallCount", int'(stallCount), 0);
        checkVal("post_reset_memTimeout", int'(memTimeout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
